// File: rtl/dt_pkg.sv
// dt_pkg: shared record framing constants and FSM state type for the loader and decisiontree.
package dt_pkg;
  typedef enum logic [1:0] {ST_SYNC, ST_PAYLOAD, ST_CHECK, ST_HOLD} state_t;
  localparam int FRAME_LEN = 9;
  localparam int PAYLOAD_LEN = FRAME_LEN - 2;
  localparam int FLAG_EDU_LSB = 0;
  localparam int FLAG_EDU_MSB = 1;
  localparam int FLAG_NET = 2;
  localparam int FLAG_EXTRA = 3;
  localparam int FLAG_RSV_LSB = 4;
  localparam int FLAG_RSV_MSB = 7;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned DEF_MAX_ATTEND = 9999;
endpackage

// File: rtl/record_validator.sv
// record_validator: combinational acceptance test for a received record frame.
module record_validator
  import dt_pkg::*;
#(
  parameter int unsigned MAX_ATTEND = DEF_MAX_ATTEND
) (
  input  logic [55:0] payload,
  input  logic [7:0]  sum,
  input  logic [7:0]  checksum,
  output logic        ok
);
  localparam logic [15:0] MAX_A = 16'(MAX_ATTEND);
  assign ok = (sum == checksum) && (payload[39:24] <= MAX_A)
           && (payload[FLAG_RSV_MSB:FLAG_RSV_LSB] == '0);
endmodule

// File: rtl/student_record_loader.sv
// student_record_loader: deframes serial student records into validated classifier features.
module student_record_loader
  import dt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = DEF_SYNC_BYTE,
  parameter int unsigned MAX_ATTEND = DEF_MAX_ATTEND
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] study_hours,
  output logic [15:0] attendance,
  output logic [15:0] past_scores,
  output logic [1:0]  parental_edu,
  output logic        internet_access,
  output logic        extracurricular,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic        rec_error,
  output logic [15:0] rec_count,
  output logic [7:0]  err_count
);
  state_t state;
  logic [2:0] cnt;
  logic [7:0] acc;
  logic [55:0] payload;
  logic ok;
  logic take;
  assign take = rx_valid && rx_ready;
  record_validator #(.MAX_ATTEND(MAX_ATTEND)) u_validator (
    .payload(payload), .sum(acc), .checksum(rx_data), .ok(ok)
  );
  // payload shifts in MSB-first so fields land at fixed big-endian positions
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SYNC;
      cnt <= '0;
      acc <= '0;
      payload <= '0;
      rx_ready <= 1'b1;
      feat_valid <= 1'b0;
      rec_error <= 1'b0;
      rec_count <= '0;
      err_count <= '0;
      study_hours <= '0;
      attendance <= '0;
      past_scores <= '0;
      parental_edu <= '0;
      internet_access <= 1'b0;
      extracurricular <= 1'b0;
    end else begin
      rec_error <= 1'b0;
      case (state)
        ST_SYNC: if (take && rx_data == SYNC_BYTE) begin
          state <= ST_PAYLOAD;
          cnt <= '0;
          acc <= '0;
        end
        ST_PAYLOAD: if (take) begin
          payload <= {payload[47:0], rx_data};
          acc <= acc ^ rx_data;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(PAYLOAD_LEN - 1)) state <= ST_CHECK;
        end
        ST_CHECK: if (take) begin
          if (ok) begin
            study_hours <= payload[55:40];
            attendance <= payload[39:24];
            past_scores <= payload[23:8];
            parental_edu <= payload[FLAG_EDU_MSB:FLAG_EDU_LSB];
            internet_access <= payload[FLAG_NET];
            extracurricular <= payload[FLAG_EXTRA];
            feat_valid <= 1'b1;
            rec_count <= rec_count + 16'd1;
            rx_ready <= 1'b0;
            state <= ST_HOLD;
          end else begin
            rec_error <= 1'b1;
            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            state <= ST_SYNC;
          end
        end
        ST_HOLD: if (feat_ready) begin
          feat_valid <= 1'b0;
          rx_ready <= 1'b1;
          state <= ST_SYNC;
        end
        default: state <= ST_SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_student_record_loader.sv
// tb_student_record_loader: directed-vector self-checking bench for student_record_loader.
module tb_student_record_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [15:0] study_hours, attendance, past_scores;
  logic [1:0] parental_edu;
  logic internet_access, extracurricular, feat_valid;
  logic feat_ready = 1'b0;
  logic rec_error;
  logic [15:0] rec_count;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;
  int gap = 0;
  always #5 clk = ~clk;
  student_record_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .study_hours(study_hours), .attendance(attendance), .past_scores(past_scores),
    .parental_edu(parental_edu), .internet_access(internet_access),
    .extracurricular(extracurricular), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .rec_error(rec_error), .rec_count(rec_count), .err_count(err_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(rx_ready), 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [71:0] f);
    for (int i = 0; i < 9; i++) send_byte(f[71 - 8*i -: 8]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic release_rec();
    @(negedge clk);
    feat_ready = 1'b1;
    @(posedge clk);
    #1 feat_ready = 1'b0;
  endtask
  initial begin
    do_reset();
    #1;
    check("rst_rx_ready", 32'(rx_ready), 1);
    check("rst_feat_valid", 32'(feat_valid), 0);
    check("rst_rec_error", 32'(rec_error), 0);
    check("rst_rec_count", 32'(rec_count), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_features", {study_hours, attendance}, 0);
    check("rst_flags", {past_scores, 12'd0, parental_edu, internet_access, extracurricular}, 0);
    send_frame(72'hA5_001F_1AAA_0056_0C_F5);
    check("a_feat_valid", 32'(feat_valid), 1);
    check("a_study", 32'(study_hours), 31);
    check("a_attend", 32'(attendance), 6826);
    check("a_past", 32'(past_scores), 86);
    check("a_edu", 32'(parental_edu), 0);
    check("a_net", 32'(internet_access), 1);
    check("a_extra", 32'(extracurricular), 1);
    check("a_rec_count", 32'(rec_count), 1);
    check("a_rx_ready", 32'(rx_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(feat_valid), 1);
      check("hold_rx_ready", 32'(rx_ready), 0);
      check("hold_study", 32'(study_hours), 31);
    end
    release_rec();
    check("rel_feat_valid", 32'(feat_valid), 0);
    check("rel_rx_ready", 32'(rx_ready), 1);
    send_frame(72'hA5_001F_1AAA_0056_0C_F4);
    check("badck_rec_error", 32'(rec_error), 1);
    check("badck_feat_valid", 32'(feat_valid), 0);
    check("badck_err_count", 32'(err_count), 1);
    check("badck_study_kept", 32'(study_hours), 31);
    check("badck_rec_count", 32'(rec_count), 1);
    @(posedge clk);
    #1 check("badck_pulse_end", 32'(rec_error), 0);
    send_frame(72'hA5_001F_2710_0056_0C_72);
    check("att10000_rec_error", 32'(rec_error), 1);
    check("att10000_err_count", 32'(err_count), 2);
    check("att10000_attend_kept", 32'(attendance), 6826);
    send_frame(72'hA5_001F_270F_0056_0C_6D);
    check("att9999_valid", 32'(feat_valid), 1);
    check("att9999_attend", 32'(attendance), 9999);
    check("att9999_rec_count", 32'(rec_count), 2);
    release_rec();
    send_frame(72'hA5_001F_1AAA_0056_1C_E5);
    check("rsv_rec_error", 32'(rec_error), 1);
    check("rsv_err_count", 32'(err_count), 3);
    gap = 2;
    send_byte(8'h00);
    send_byte(8'h13);
    send_frame(72'hA5_00A5_0002_0100_07_A1);
    gap = 0;
    check("embsync_valid", 32'(feat_valid), 1);
    check("embsync_study", 32'(study_hours), 16'h00A5);
    check("embsync_attend", 32'(attendance), 2);
    check("embsync_past", 32'(past_scores), 256);
    check("embsync_edu", 32'(parental_edu), 3);
    check("embsync_net", 32'(internet_access), 1);
    check("embsync_extra", 32'(extracurricular), 0);
    check("embsync_rec_count", 32'(rec_count), 3);
    check("embsync_err_count", 32'(err_count), 3);
    release_rec();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h1F);
    send_byte(8'h1A);
    send_byte(8'hAA);
    do_reset();
    #1;
    check("midrst_rec_error", 32'(rec_error), 0);
    check("midrst_feat_valid", 32'(feat_valid), 0);
    check("midrst_study", 32'(study_hours), 0);
    send_frame(72'hA5_001F_1AAA_0056_0C_F5);
    check("midrst_rec_count", 32'(rec_count), 1);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_attend", 32'(attendance), 6826);
    release_rec();
    for (int i = 1; i <= 256; i++) begin
      send_frame(72'hA5_001F_1AAA_0056_0C_F4);
      check("sat_rec_error", 32'(rec_error), 1);
      if (i == 254) check("sat_err_254", 32'(err_count), 254);
      if (i == 255) check("sat_err_255", 32'(err_count), 255);
    end
    check("sat_err_final", 32'(err_count), 255);
    check("sat_rec_count", 32'(rec_count), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/student_record_loader.md
STUDENT_RECORD_LOADER -- requirements
Module: student_record_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_ATTEND, default 9999, highest legal attendance value (0-9999 scaled percent).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 rx_data  input  8  incoming serial record byte.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready.
REQ-008 study_hours, attendance, past_scores  output  16 each  decoded features for the decisiontree classifier.
REQ-009 parental_edu  output  2  00 High School ... 11 PhD.
REQ-010 internet_access, extracurricular  output  1 each  decoded flags.
REQ-011 feat_valid  output  1  feature outputs hold a validated record.
REQ-012 feat_ready  input  1  consumer takes record; handoff when feat_valid && feat_ready.
REQ-013 rec_error  output  1  one-cycle pulse on rejected frame.
REQ-014 rec_count  output  16  good records delivered; err_count  output  8  rejected frames.

Function
REQ-015 Frame SHALL be 9 bytes: SYNC_BYTE, study_hours hi/lo, attendance hi/lo, past_scores hi/lo, flag byte, checksum; multi-byte fields big-endian.
REQ-016 Flag byte SHALL map [1:0] parental_edu, [2] internet_access, [3] extracurricular; [7:4] reserved, required zero.
REQ-017 Checksum SHALL equal XOR of the 7 payload bytes (sync byte excluded).
REQ-018 FSM states SHALL be SYNC, PAYLOAD, CHECK, HOLD; reset state SYNC.
REQ-019 SYNC: bytes not equal to SYNC_BYTE SHALL be dropped; SYNC_BYTE moves to PAYLOAD with byte counter 0.
REQ-020 PAYLOAD: each accepted byte stored and XOR-accumulated; after 7th byte move to CHECK.
REQ-021 CHECK: accepted checksum byte evaluated; frame rejected if checksum mismatch, attendance > MAX_ATTEND, or reserved flag bits non-zero.
REQ-022 Good frame: feature outputs loaded and feat_valid high the cycle after checksum acceptance; rec_count increments (wraps at 65535->0); move to HOLD.
REQ-023 Rejected frame: rec_error pulses the cycle after checksum acceptance; err_count increments, saturating at 255; feature outputs unchanged; return to SYNC.
REQ-024 rx_ready SHALL be high in SYNC, PAYLOAD, CHECK and low in HOLD.
REQ-025 HOLD: feature outputs stable, feat_valid high until feat_ready sampled high; then feat_valid low next cycle and state SYNC.
REQ-026 A SYNC_BYTE value arriving inside PAYLOAD/CHECK SHALL be treated as data (no resynchronisation).
REQ-027 Gaps (rx_valid low) at any point SHALL stall the FSM without loss of state.

Reset
REQ-028 Reset SHALL force SYNC, byte counter 0, XOR accumulator 0, rx_ready high (from first post-reset cycle), feat_valid 0, rec_error 0, rec_count 0, err_count 0, all feature outputs 0.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial/held record without rec_error.

Structure
REQ-030 Shared package dt_pkg SHALL hold the FSM state enum, flag-bit positions, frame length (9) and default SYNC_BYTE/MAX_ATTEND constants, shared with decisiontree.
REQ-031 Frame checks SHALL be a combinational sub-module record_validator (inputs: payload, checksum; output: ok).
REQ-032 Target 120-400 lines RTL; no memories.

Verification
REQ-033 Frame A5 00 1F 1A AA 00 56 0C F5 -> feat_valid, study_hours=31, attendance=6826, past_scores=86, parental_edu=00, internet_access=1, extracurricular=1, rec_count=1.
REQ-034 Same frame with checksum F4 -> rec_error one pulse, no feat_valid, err_count=1, outputs unchanged.
REQ-035 Attendance bytes 27 10 (10000) with correct checksum -> rejected, err_count increments.
REQ-036 feat_ready held low 5 cycles after good frame -> rx_ready low, feat_valid high, outputs stable; feat_ready high -> feat_valid low next cycle, rx_ready high.
REQ-037 Bytes 00 13 before sync, then reset after 4 payload bytes, then full good frame -> only final frame delivered, rec_count=1, err_count=0.
REQ-038 256 bad-checksum frames -> err_count saturates at 255, 256th still pulses rec_error.
